// File: rtl/array_stream_loader.sv
// Serial-to-parallel loader: packs a valid/ready word stream into a
// DEPTH x WIDTH array and presents each frame with its own handshake.
module array_stream_loader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] arr [DEPTH-1:0],
  output logic             arr_valid,
  input  logic             arr_ready,
  output logic [CNT_W-1:0] arr_count
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             in_ready_q;
  logic             in_ready_d;
  logic             arr_valid_q;
  logic             arr_valid_d;
  logic [WIDTH-1:0] arr_q [DEPTH-1:0];
  logic [WIDTH-1:0] arr_d [DEPTH-1:0];

  logic accept;
  logic end_of_frame;

  assign accept       = in_valid & in_ready_q;
  assign end_of_frame = in_last | (idx_q == IDX_W'(DEPTH - 1));

  // Next-state: fill one entry per accepted word, hold until consumed.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    arr_valid_d = arr_valid_q;
    for (int k = 0; k < int'(DEPTH); k++) begin
      arr_d[k] = arr_q[k];
    end
    unique case (state_q)
      FILL: begin
        in_ready_d  = 1'b1;
        arr_valid_d = 1'b0;
        if (accept) begin
          arr_d[idx_q] = in_data;
          if (end_of_frame) begin
            state_d     = HOLD;
            cnt_d       = CNT_W'(idx_q) + CNT_W'(1);
            idx_d       = '0;
            in_ready_d  = 1'b0;
            arr_valid_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        in_ready_d  = 1'b0;
        arr_valid_d = 1'b1;
        if (arr_ready) begin
          state_d     = FILL;
          cnt_d       = '0;
          idx_d       = '0;
          in_ready_d  = 1'b1;
          arr_valid_d = 1'b0;
          for (int k = 0; k < int'(DEPTH); k++) begin
            arr_d[k] = '0;
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State register; reset discards any partial frame.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q     <= FILL;
      idx_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      arr_valid_q <= 1'b0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        arr_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      arr_valid_q <= arr_valid_d;
      for (int k = 0; k < int'(DEPTH); k++) begin
        arr_q[k] <= arr_d[k];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign arr_valid = arr_valid_q;
  assign arr_count = cnt_q;
  assign arr       = arr_q;

endmodule
